// File: rtl/fetch.sv
// rtl/fetch.sv - instruction fetch stage with local instruction memory, stall, redirect and stop detection (optional FETCH_PERF_EN bubble counter)
module fetch #(
  parameter int          INST_SIZE = 10,
  parameter logic [31:0] RESET_PC  = 32'h0
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 prog_we,
  input  logic [INST_SIZE-1:0] prog_addr,
  input  logic [31:0]          prog_data,
  input  logic                 start,
  input  logic                 stall,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic [31:0]          pc,
  output logic [31:0]          inst,
  output logic                 valid,
  output logic                 halted,
  output logic [31:0]          perf_bubbles
);

  localparam int DEPTH = 1 << INST_SIZE;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  state_t               state;
  state_t               state_nx;
  logic [31:0]          mem [DEPTH];
  logic [31:0]          fetch_pc;
  logic [31:0]          sel_pc;
  logic [INST_SIZE-1:0] addr;
  logic                 is_stop;
  logic                 halt_now;
  logic                 advance;

  // Next-state and fetch-address selection; a redirect replaces fetch_pc in the same cycle
  always_comb begin
    state_nx = state;
    sel_pc   = redirect_valid ? redirect_pc : fetch_pc;
    addr     = sel_pc[INST_SIZE+1:2];
    is_stop  = (inst[31:26] == 6'b000000) && (inst[5:0] == 6'b111110);
    halt_now = (state == RUN) && !stall && valid && is_stop;
    advance  = (state == RUN) && !stall && !halt_now;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (halt_now) state_nx = HALT;
      HALT:    state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  // Loader writes land only while idle and never during reset; contents survive reset
  always_ff @(posedge clk) begin
    if (rstn && (state == IDLE) && prog_we) mem[prog_addr] <= prog_data;
  end

  // Presented pc/inst pair; the memory read doubles as the synchronous read port
  always_ff @(posedge clk) begin
    if (!rstn) begin
      fetch_pc <= RESET_PC;
      pc       <= RESET_PC;
      inst     <= 32'h0;
      valid    <= 1'b0;
      halted   <= 1'b0;
    end else if (halt_now) begin
      valid  <= 1'b0;
      halted <= 1'b1;
    end else if (advance) begin
      inst     <= mem[addr];
      pc       <= sel_pc;
      valid    <= 1'b1;
      fetch_pc <= sel_pc + 32'd4;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt;

  // Saturating count of stalled RUN cycles
  always_ff @(posedge clk) begin
    if (!rstn)
      bubble_cnt <= 32'h0;
    else if ((state == RUN) && stall && (bubble_cnt != 32'hFFFF_FFFF))
      bubble_cnt <= bubble_cnt + 32'd1;
  end

  assign perf_bubbles = bubble_cnt;
`else
  assign perf_bubbles = 32'h0;
`endif

endmodule

// File: doc/fetch.md
Name: fetch

Overview:
- Instruction-fetch stage directly upstream of the decode stage; supplies the `pc`/`inst` pair that decode consumes.
- Holds instruction memory: 2^INST_SIZE words, synchronous read. The memory is loaded by the program loader while the core is idle.
- Produces one instruction per cycle. It honours a stall from the pipeline and accepts a same-cycle redirect carrying decode's computed next PC.
- Detects the stop instruction and parks the core in a halted state.

Parameters:
- INST_SIZE, 10, instruction memory address width in words (depth 2^INST_SIZE).
- RESET_PC, 32'h0, PC loaded on reset and fetched first after start.

Ports:
- clk  input  1  clock, all logic on posedge.
- rstn  input  1  reset, synchronous, active-low.
- prog_we  input  1  loader write strobe.
- prog_addr  input  INST_SIZE  loader word address.
- prog_data  input  32  loader write data.
- start  input  1  pulse; begins fetching from RESET_PC.
- stall  input  1  downstream not accepting; freeze stage.
- redirect_valid  input  1  take redirect_pc as the next fetch address.
- redirect_pc  input  32  next PC from decode (npc).
- pc  output  32  PC of the presented instruction.
- inst  output  32  presented instruction word.
- valid  output  1  pc/inst hold a real instruction.
- halted  output  1  stop instruction retired from fetch.
- perf_bubbles  output  32  bubble counter (optional feature).

Behaviour:
- Reset (rstn=0 at posedge) has highest priority:
  - state=IDLE, fetch_pc=RESET_PC, pc=RESET_PC, inst=0, valid=0, halted=0, perf_bubbles=0.
  - Memory contents are not cleared.
  - Reset mid-RUN or in HALT behaves the same: return to IDLE, no partial writes.
- States: IDLE, RUN, HALT.
- IDLE:
  - prog_we=1 writes mem[prog_addr]=prog_data.
  - start=1 moves to RUN at that edge; a write in the same cycle still completes.
  - Outputs hold their reset values.
- RUN:
  - prog_we is ignored.
  - The address `a` is the word index: redirect_pc[INST_SIZE+1:2] if redirect_valid, else fetch_pc[INST_SIZE+1:2]. Upper bits are ignored, so addresses wrap modulo depth. Bits [1:0] are ignored.
  - Each edge with stall=0 and no halt condition:
    - inst<=mem[a].
    - pc<=(redirect_valid ? redirect_pc : fetch_pc).
    - valid<=1.
    - fetch_pc<=that pc+4, with 32-bit wrap.
- Latency:
  - Start edge E0, first read at E1. valid=1 with pc=RESET_PC after E1.
  - Redirect has zero bubbles: the target instruction appears after the edge at which redirect_valid is sampled.
- stall=1 in RUN:
  - Memory read is disabled.
  - pc, inst, valid and fetch_pc all hold.
  - redirect_valid is ignored while stalled.
- Halt condition: valid=1, stall=0, and inst is the stop instruction (inst[31:26]=6'b000000 and inst[5:0]=6'b111110).
  - At that edge, state->HALT, valid<=0, halted<=1, and no new fetch.
  - halt has priority over a simultaneous redirect.
- HALT: all outputs hold (valid=0, halted=1) until reset. start, prog_we, stall and redirect are ignored.
- start outside IDLE is ignored.

Optional Feature:
- Macro: FETCH_PERF_EN.
- Defined: a 32-bit counter counts RUN cycles in which the stage does not advance (stall=1). It is cleared by reset, saturates at 32'hFFFFFFFF, and is driven onto perf_bubbles.
- Undefined: no counter logic; perf_bubbles is tied to 0.

Test Plan:
- Load mem[0..3]=0x20010001,0x20020002,0x20030003,0x20040004; start, stall=0 -> after E1..E4: pc=0,4,8,12 with the matching inst, valid=1 from E1.
- Stall held for 3 cycles while pc=4 is presented -> pc=4 and inst=0x20020002 are stable; after release, the next edge presents pc=8; perf_bubbles=3 when FETCH_PERF_EN is defined, else 0.
- Redirect: at pc=4, redirect_valid=1 with redirect_pc=0x40 -> next edge pc=0x40, inst=mem[16]; following edge pc=0x44.
- Stop: mem[2]=0x0000003E -> after pc=8 is presented and accepted, halted=1 and valid=0, both held for 10 cycles.
- Wrap: INST_SIZE=10, redirect to 0xFFC -> inst=mem[1023]; next pc=0x1000 with inst=mem[0].
- Robustness:
  - prog_we during RUN leaves memory unchanged.
  - rstn=0 mid-RUN -> state IDLE, valid=0, pc=RESET_PC.
  - Memory retained: start again replays the same sequence.
